systolic_mmu_param: RTL

Parametrised N x N weight-stationary systolic matrix-multiply unit. It is the next generation of the fixed 4x4 MMU. The block adds the following over the 4x4 MMU:
- synchronous reset
- ready/valid handshakes
- internal input skew and output de-skew, so callers present unskewed vectors
- signed/unsigned mode
- a valid-tagged output

It sits between the activation buffer and the accumulator/activation stage.

---
 rtl/systolic_mmu_param_if.sv | 27 ++
 rtl/systolic_mmu_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_mmu_param_if.sv
// Bus bundle for the parametrised systolic MMU: weight-load and data
// handshakes plus the valid-tagged result lanes.
interface systolic_mmu_param_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 32
);
  logic            wt_valid;
  logic            wt_ready;
  logic [N*DW-1:0] wt_row;
  logic            data_valid;
  logic            data_ready;
  logic [N*DW-1:0] data_in;
  logic            out_valid;
  logic [N*AW-1:0] acc_out;
  logic            busy;

  modport master (
    output wt_valid, wt_row, data_valid, data_in,
    input  wt_ready, data_ready, out_valid, acc_out, busy
  );

  modport slave (
    input  wt_valid, wt_row, data_valid, data_in,
    output wt_ready, data_ready, out_valid, acc_out, busy
  );
endinterface

// File: rtl/systolic_mmu_param.sv
// N x N weight-stationary systolic matrix-multiply unit.
// Callers present unskewed vectors; the block skews them into the array,
// de-skews the column sums and emits y[j] = sum_i x[i]*W[i][j] exactly
// 2*N cycles after acceptance, one result per cycle in acceptance order.
module systolic_mmu_param #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int AW     = 32,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  systolic_mmu_param_if.slave bus
);
  localparam int LAT = 2 * N;
  localparam int KW  = $clog2(N);
  localparam int IW  = $clog2(LAT + 1);

  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic [IW-1:0]   inflight;
  logic            wt_ready, data_ready, wt_fire, data_fire;
  logic [LAT-2:0]  tok;
  logic            out_valid;
  logic [N*AW-1:0] acc;
  logic [DW-1:0]   a_in [N][N];
  logic [AW-1:0]   ps [N][N];
  logic [AW-1:0]   col_out [N];

  // Product of one activation and one weight, widened to the accumulator
  // width with sign or zero extension depending on the operand mode.
  function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] w);
    logic signed [2*DW-1:0] sp;
    logic [2*DW-1:0]        up;
    logic [AW-1:0]          r;
    sp = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{w[DW-1]}}, w});
    up = {{DW{1'b0}}, a} * {{DW{1'b0}}, w};
    if (SIGNED != 0) r = AW'(sp);
    else             r = AW'(up);
    return r;
  endfunction

  // Data always wins; a weight beat in READY only lands when the pipe is empty,
  // so weights never change under a vector that is still in flight.
  assign data_ready = (state == READY);
  assign wt_ready   = (state != READY) || (inflight == '0 && !bus.data_valid);
  assign wt_fire    = bus.wt_valid && wt_ready;
  assign data_fire  = bus.data_valid && data_ready;

  // Load-FSM state and weight row pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // Each accepted beat advances the row pointer; the last row completes the load.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    if (wt_fire) begin
      if (k == KW'(N - 1)) begin
        k_nxt     = '0;
        state_nxt = READY;
      end else begin
        k_nxt     = k + KW'(1);
        state_nxt = LOADING;
      end
    end
  end

  // Count of accepted vectors whose result has not yet been presented.
  always_ff @(posedge clk) begin
    if (rst) inflight <= '0;
    else begin
      case ({data_fire, out_valid})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Input skew: lane i is delayed i cycles so rows are fed diagonally.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] lane;
    assign lane = data_fire ? bus.data_in[i*DW +: DW] : '0;
    if (i == 0) begin : g_direct
      assign a_in[0][0] = lane;
    end else begin : g_chain
      logic [DW-1:0] chain [i];
      // Shift register delaying this lane by its row index.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < i; s++) chain[s] <= '0;
        end else begin
          chain[0] <= lane;
          for (int s = 1; s < i; s++) chain[s] <= chain[s-1];
        end
      end
      assign a_in[i][0] = chain[i-1];
    end
  end

  // Processing elements: activations flow right, partial sums flow down.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic [DW-1:0] w;
      logic [AW-1:0] psum_in, p_q;
      if (i == 0) begin : g_top
        assign psum_in = '0;
      end else begin : g_inner
        assign psum_in = ps[i-1][j];
      end
      // Stationary weight capture and multiply-accumulate of the passing sum.
      always_ff @(posedge clk) begin
        if (rst) begin
          w   <= '0;
          p_q <= '0;
        end else begin
          if (wt_fire && k == KW'(i)) w <= bus.wt_row[j*DW +: DW];
          p_q <= psum_in + mul_ext(a_in[i][j], w);
        end
      end
      assign ps[i][j] = p_q;
      if (j < N - 1) begin : g_fwd
        logic [DW-1:0] a_q;
        // Forward the activation to the neighbour on the right.
        always_ff @(posedge clk) begin
          if (rst) a_q <= '0;
          else     a_q <= a_in[i][j];
        end
        assign a_in[i][j+1] = a_q;
      end
    end
  end

  // Output de-skew: column j waits N-1-j cycles so all columns line up.
  for (genvar j = 0; j < N; j++) begin : g_deskew
    if (j == N - 1) begin : g_direct
      assign col_out[j] = ps[N-1][j];
    end else begin : g_chain
      logic [AW-1:0] dq [N-1-j];
      // Delay line aligning this column with the last one.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < N - 1 - j; s++) dq[s] <= '0;
        end else begin
          dq[0] <= ps[N-1][j];
          for (int s = 1; s < N - 1 - j; s++) dq[s] <= dq[s-1];
        end
      end
      assign col_out[j] = dq[N-2-j];
    end
  end

  // Validity token riding alongside each accepted vector.
  always_ff @(posedge clk) begin
    if (rst) tok <= '0;
    else     tok <= {tok[LAT-3:0], data_fire};
  end

  // Result register: loads aligned lanes with the token, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      acc       <= '0;
    end else begin
      out_valid <= tok[LAT-2];
      if (tok[LAT-2]) begin
        for (int j = 0; j < N; j++) acc[j*AW +: AW] <= col_out[j];
      end
    end
  end

  assign bus.wt_ready   = wt_ready;
  assign bus.data_ready = data_ready;
  assign bus.out_valid  = out_valid;
  assign bus.acc_out    = acc;
  assign bus.busy       = (inflight != '0);
endmodule
